// File: rtl/uart_alu_pkg.sv
// +-----------------------------------------------------------------------------
// | Package : uart_alu_pkg
// | Shared types and constants for the UART ALU receive-side packet framer.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package uart_alu_pkg;

  typedef enum logic [2:0] {
    ST_OPCODE  = 3'd0,
    ST_RSVD    = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_HDR     = 3'd4,
    ST_PAYLOAD = 3'd5
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_BAD_RSVD = 2'b01,
    ERR_BAD_LEN  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

  localparam logic [15:0] HDR_BYTES = 16'd4;
  localparam logic [7:0]  RSVD_BYTE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/uart_pkt_timer.sv
// +-----------------------------------------------------------------------------
// | Module  : uart_pkt_timer
// | Inter-byte idle counter: counts while enabled, pulses expire on the limit.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module uart_pkt_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 33178
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == C_LAST);
  // Expire fires on the edge where the count would reach the limit.
  assign expire_o  = enable_i & ~clear_i & w_at_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_pkt_parser.sv
// +-----------------------------------------------------------------------------
// | Module  : uart_pkt_parser
// | Decodes the 4-byte UART ALU header, then passes payload through with tlast.
// | Optional inter-byte timeout compiled in with UART_PKT_TIMEOUT_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module uart_pkt_parser
  import uart_alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 33178
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  output logic [7:0]  hdr_opcode_o,
  output logic [15:0] hdr_length_o,
  output logic        hdr_valid_o,
  input  logic        hdr_ready_i,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic        m_axis_tlast_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  parser_state_t r_state;
  logic [7:0]    r_opcode_tmp;
  logic [7:0]    r_len_lo;
  logic [15:0]   r_remaining;
  logic [7:0]    r_hdr_opcode;
  logic [15:0]   r_hdr_length;
  logic          r_hdr_valid;
  logic          r_err;
  err_code_t     r_err_code;

  logic          w_in_hdr_bytes;
  logic          w_in_payload;
  logic          w_s_accept;
  logic [15:0]   w_length;
  logic          w_expire;

  assign w_in_hdr_bytes = (r_state == ST_OPCODE) || (r_state == ST_RSVD) ||
                          (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI);
  assign w_in_payload   = (r_state == ST_PAYLOAD);
  assign w_s_accept     = s_axis_tvalid_i & s_axis_tready_o;
  assign w_length       = {s_axis_tdata_i, r_len_lo};

  assign s_axis_tready_o = w_in_hdr_bytes | (w_in_payload & m_axis_tready_i);
  assign m_axis_tdata_o  = s_axis_tdata_i;
  assign m_axis_tvalid_o = w_in_payload & s_axis_tvalid_i;
  assign m_axis_tlast_o  = w_in_payload & (r_remaining == 16'd1);

  assign hdr_opcode_o = r_hdr_opcode;
  assign hdr_length_o = r_hdr_length;
  assign hdr_valid_o  = r_hdr_valid;
  assign err_o        = r_err;
  assign err_code_o   = r_err_code;

`ifdef UART_PKT_TIMEOUT_EN
  logic w_tmr_clear;
  logic w_tmr_enable;

  assign w_tmr_clear  = w_s_accept | (r_state == ST_OPCODE) | (r_state == ST_HDR);
  assign w_tmr_enable = ~s_axis_tvalid_i &
                        ((r_state == ST_RSVD) || (r_state == ST_LEN_LO) ||
                         (r_state == ST_LEN_HI) || (r_state == ST_PAYLOAD));

  uart_pkt_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (w_tmr_clear),
    .enable_i (w_tmr_enable),
    .expire_o (w_expire)
  );
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_OPCODE;
      r_opcode_tmp <= '0;
      r_len_lo     <= '0;
      r_remaining  <= '0;
      r_hdr_opcode <= '0;
      r_hdr_length <= '0;
      r_hdr_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_OPCODE: begin
          if (w_s_accept) begin
            r_opcode_tmp <= s_axis_tdata_i;
            r_state      <= ST_RSVD;
          end
        end
        ST_RSVD: begin
          if (w_s_accept) begin
            // A bad reserved byte is dropped; the next byte is treated as an opcode.
            if (s_axis_tdata_i != RSVD_BYTE) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_BAD_RSVD;
              r_state    <= ST_OPCODE;
            end else begin
              r_state <= ST_LEN_LO;
            end
          end
        end
        ST_LEN_LO: begin
          if (w_s_accept) begin
            r_len_lo <= s_axis_tdata_i;
            r_state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (w_s_accept) begin
            r_hdr_opcode <= r_opcode_tmp;
            r_hdr_length <= w_length;
            if (w_length < HDR_BYTES) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_BAD_LEN;
              r_state    <= ST_OPCODE;
            end else begin
              r_remaining <= w_length - HDR_BYTES;
              r_hdr_valid <= 1'b1;
              r_state     <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (hdr_ready_i) begin
            r_hdr_valid <= 1'b0;
            r_state     <= (r_remaining == 16'd0) ? ST_OPCODE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_s_accept) begin
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_state <= ST_OPCODE;
            end
          end
        end
        default: r_state <= ST_OPCODE;
      endcase

      if (w_expire) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
        r_state    <= ST_OPCODE;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_pkt_parser.md
# uart_pkt_parser

Receive-side packet framer for the UART ALU. It consumes the byte stream from the UART receiver (AXI-Stream, one byte per beat) and decodes the 4-byte packet header: opcode, reserved 0x00, length low byte, length high byte. It presents the header on a handshake, then passes the payload bytes through with `tlast` on the final byte. It sits between the UART RX and the ALU/echo datapath in the PLL clock domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 33178: inter-byte idle limit in clock cycles (1 ms at 33.178 MHz). Used only when the timeout is compiled in.

Ports:
- `clk_i`  in  1  single clock (PLL output domain).
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata_i`  in  8  received byte.
- `s_axis_tvalid_i`  in  1  byte valid.
- `s_axis_tready_o`  out  1  parser accepts byte.
- `hdr_opcode_o`  out  8  decoded opcode.
- `hdr_length_o`  out  16  total packet length in bytes, header included.
- `hdr_valid_o`  out  1  header fields valid.
- `hdr_ready_i`  in  1  consumer accepts header.
- `m_axis_tdata_o`  out  8  payload byte.
- `m_axis_tvalid_o`  out  1  payload valid.
- `m_axis_tready_i`  in  1  downstream ready.
- `m_axis_tlast_o`  out  1  last payload byte of packet.
- `err_o`  out  1  one-cycle error pulse.
- `err_code_o`  out  2  cause: 01 BAD_RSVD, 10 BAD_LEN, 11 TIMEOUT. Holds the last error.

## Operation
- FSM states: OPCODE, RSVD, LEN_LO, LEN_HI, HDR, PAYLOAD.
- In OPCODE, RSVD, LEN_LO and LEN_HI: `s_axis_tready_o`=1. Each accepted byte is latched and the FSM advances.
- RSVD: a byte other than 0x00 pulses `err_o` with BAD_RSVD and returns to OPCODE. The byte is discarded; this is the resync.
- LEN_HI: length is {hi,lo}.
  - length < 4: BAD_LEN error, return to OPCODE, no header issued.
  - otherwise: go to HDR and load the remaining counter with length-4 (16-bit, no underflow possible).
- HDR: `hdr_valid_o`=1, `s_axis_tready_o`=0. When `hdr_ready_i` is high, the header is accepted.
  - remaining==0: go to OPCODE.
  - otherwise: go to PAYLOAD.
- PAYLOAD: combinational pass-through. `m_axis_tdata_o`=`s_axis_tdata_i`, `m_axis_tvalid_o`=`s_axis_tvalid_i`, `s_axis_tready_o`=`m_axis_tready_i`.
  - remaining decrements on each beat with valid&ready.
  - `m_axis_tlast_o`=(remaining==1).
  - After the beat where remaining==1, go to OPCODE.
- `hdr_opcode_o` and `hdr_length_o` stay stable from HDR until the next LEN_HI acceptance.

## Timing
- Reset values: state OPCODE, `hdr_valid_o`=0, `m_axis_tvalid_o`=0, `m_axis_tlast_o`=0, `err_o`=0, `err_code_o`=00, `hdr_opcode_o`=0, `hdr_length_o`=0, remaining=0.
- `s_axis_tready_o` is decoded from state, so it is 1 during reset.
- `hdr_valid_o` rises the cycle after the LEN_HI byte is accepted. It holds until the handshake and drops the cycle after it.
- Payload latency is zero cycles (combinational).
- Header stage throughput is one byte per cycle; there are no bubbles in the header states.
- `err_o` is high for exactly one cycle: the cycle after the offending byte is accepted, or the cycle after the timeout fires.
- Reset asserted mid-packet aborts immediately. The FSM returns to OPCODE and no `tlast` is emitted.
- If the header is stalled (HDR with `hdr_ready_i`=0), upstream is backpressured indefinitely.

## Configuration
- `UART_PKT_TIMEOUT_EN` defined:
  - An idle counter clears on every accepted input byte and on entry to OPCODE.
  - It counts while the state is in {RSVD, LEN_LO, LEN_HI, PAYLOAD} and `s_axis_tvalid_i`=0.
  - When it reaches `TIMEOUT_CYCLES`, `err_o` pulses with TIMEOUT and the FSM returns to OPCODE.
  - A packet truncated in PAYLOAD gets no `tlast`; downstream flushes on `err_o`.
- `UART_PKT_TIMEOUT_EN` undefined: no counter and no TIMEOUT code. The FSM waits forever and `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `uart_alu_pkg` holds:
  - the parser state enum;
  - the `err_code_t` enum (BAD_RSVD, BAD_LEN, TIMEOUT);
  - `HDR_BYTES`=4;
  - `RSVD_BYTE`=8'h00.
- Sub-module `uart_pkt_timer` is the idle counter: clear/enable in, expire pulse out. It is instantiated only under `UART_PKT_TIMEOUT_EN`.

## Test plan
- Bytes AD 00 08 00 11 22 33 44, all ready -> header opcode=AD, length=0x0008. Payload 11,22,33,44 with `tlast` only on 44. FSM ends in OPCODE.
- Bytes EC 00 04 00 -> header EC/0x0004 with no payload beats. The next byte is parsed as an opcode.
- Bytes 88 05 ... -> `err_o` pulses with code 01 and no header is issued. The following 88 00 06 00 AA BB yields header length 6 and payload AA, BB(`tlast`).
- Bytes 88 00 02 00 -> BAD_LEN (10), no header. Next packet parses normally.
- Header stalled 10 cycles, then payload with `m_axis_tready_i` toggling -> `s_axis_tready_o`=0 during the stall. Payload order is preserved and the byte count equals length-4.
- With the macro: send AD 00 08 00 11, then idle `TIMEOUT_CYCLES` -> TIMEOUT (11) pulses once and FSM is in OPCODE. Reset asserted mid-payload -> all outputs at reset values.
